tmds_rx_decoder: RTL and testbench
==================================

// Module: tmds_rx_decoder
// PURPOSE
//   Receive-side TMDS channel logic: takes raw 10-bit words from a 1:10 ISERDES
//   deserializer, finds word alignment by issuing bitslip pulses until control
//   tokens appear, then decodes each word to 8-bit pixel data or 2-bit control.
//   One instance per TMDS data channel (B/G/R) in the DVI-to-RGB path.
// PARAMETERS
//   CTRL_RUN      16    consecutive control tokens required to declare lock
//   SEARCH_WINDOW 2048  cycles in SEARCH without a full run before a bitslip
//   SLIP_SETTLE   4     cycles ignored after bitslip while the ISERDES re-frames
//   LOSS_TIMEOUT  4096  cycles in LOCKED with no control token before lock drops
// PORTS
//   pixel_clk  in   1   pixel clock, all logic on rising edge
//   rst        in   1   synchronous, active-low reset
//   din        in   10  raw deserialized word, din[0] = first serial bit
//   bitslip    out  1   one-cycle pulse to ISERDES BITSLIP
//   locked     out  1   word alignment established
//   slip_count out  4   bitslips since last lock attempt, wraps 9->0
//   valid      out  1   dout/ctrl/de are meaningful (= locked, registered)
//   de         out  1   1 = data word, 0 = control period
//   dout       out  8   decoded pixel byte (0 when de=0)
//   ctrl       out  2   {c1,c0} of last control token (held during data)
// BEHAVIOUR
//   Reset (rst=0 at edge): bitslip=0, locked=0, slip_count=0, valid=0, de=0,
//     dout=0, ctrl=0; FSM -> SEARCH; all counters 0. Wins over every other event.
//   Control tokens: 10'h354->00, 10'h0AB->01, 10'h154->10, 10'h2AB->11.
//   Decode (combinational, then registered; latency 1 cycle din->outputs):
//     q = din[9] ? ~din[7:0] : din[7:0]; d[0]=q[0];
//     i=1..7: d[i] = din[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
//   FSM:
//     SEARCH: run counter +1 per control token, cleared on any other word.
//       run reaches CTRL_RUN -> LOCKED, locked=1 next cycle, slip_count held.
//       window counter reaches SEARCH_WINDOW-1 -> pulse bitslip 1 cycle,
//       slip_count+1 (9 wraps to 0), -> SLIP_WAIT. Both same cycle: lock wins.
//     SLIP_WAIT: ignore din SLIP_SETTLE cycles, clear run/window, -> SEARCH.
//     LOCKED: silence counter cleared on every control token; reaching
//       LOSS_TIMEOUT -> SEARCH, locked=0 next cycle, slip_count cleared.
//   Outputs while not LOCKED: valid=0, de=0, dout=0, ctrl holds.
//   While LOCKED: control token -> de=0, ctrl updated, dout=0; other word ->
//     de=1, dout=decoded byte. Illegal words are decoded as data, never flagged.
//   bitslip never asserted two consecutive cycles; never asserted in LOCKED.
//   Counters saturate-free: sized to their parameter via $clog2, no overflow.
// STRUCTURE
//   tmds_pkg: control token localparams, ctrl<->token mapping, tmds_decode()
//     function (shared with the transmit-side encoder for testbench checking).
//   Sub-module tmds_word_align: SEARCH/SLIP_WAIT/LOCKED FSM, run/window/silence
//     counters, bitslip, slip_count, locked. Top adds decode + output registers.
// TESTING
//   Reset: drive rst=0 3 cycles with din=10'h354 -> all outputs 0, no bitslip.
//   Lock: aligned 10'h354 x16 -> locked=1 cycle after 16th, ctrl=00, de=0, valid=1.
//   Align: stream of 10'h0AB rotated by 3 bits -> bitslip pulses every
//     SEARCH_WINDOW+SLIP_SETTLE cycles, lock after model's slip count, slip_count match.
//   Decode: locked, din=10'h100 -> dout=8'h00 de=1; din=10'h2FF -> dout=8'hFE;
//     random bytes via TX encoder model -> exact match, latency 1.
//   Loss: locked, then 10'h100 for LOSS_TIMEOUT cycles -> locked=0, valid=0, SEARCH.
//   Reset mid-SLIP_WAIT: rst=0 the cycle after bitslip -> slip_count=0, SEARCH,
//     no further bitslip until a new SEARCH_WINDOW elapses.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, align FSM states and the
// 10b->8b data decode used by the receive channel.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } align_state_e;

    function automatic logic is_ctrl_token(input logic [9:0] w);
        logic hit;
        case (w)
            TOK_C00, TOK_C01, TOK_C10, TOK_C11: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [1:0] token_to_ctrl(input logic [9:0] w);
        logic [1:0] c;
        case (w)
            TOK_C00: c = 2'b00;
            TOK_C01: c = 2'b01;
            TOK_C10: c = 2'b10;
            TOK_C11: c = 2'b11;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    function automatic logic [9:0] ctrl_to_token(input logic [1:0] c);
        logic [9:0] w;
        case (c)
            2'b00:   w = TOK_C00;
            2'b01:   w = TOK_C01;
            2'b10:   w = TOK_C10;
            2'b11:   w = TOK_C11;
            default: w = TOK_C00;
        endcase
        return w;
    endfunction

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_word_align.sv
// Word-alignment FSM for one TMDS channel: searches for a run of control
// tokens, bitslips the deserializer when none is found, and tracks lock.
module tmds_word_align
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN      = 16,
    parameter int SEARCH_WINDOW = 2048,
    parameter int SLIP_SETTLE   = 4,
    parameter int LOSS_TIMEOUT  = 4096
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ctrl_tok_i,
    output logic       bitslip_o,
    output logic       locked_o,
    output logic       lock_next_o,
    output logic [3:0] slip_count_o
);

    localparam int RUN_W = (CTRL_RUN > 1)      ? $clog2(CTRL_RUN)      : 1;
    localparam int WIN_W = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
    localparam int SET_W = (SLIP_SETTLE > 1)   ? $clog2(SLIP_SETTLE)   : 1;
    localparam int SIL_W = (LOSS_TIMEOUT > 1)  ? $clog2(LOSS_TIMEOUT)  : 1;

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CTRL_RUN - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);
    localparam logic [SIL_W-1:0] SIL_LAST = SIL_W'(LOSS_TIMEOUT - 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
    localparam logic [SIL_W-1:0] SIL_ONE  = SIL_W'(1);

    align_state_e     state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [SIL_W-1:0] sil_q, sil_d;
    logic             bitslip_q, bitslip_d;
    logic             locked_q, locked_d;
    logic [3:0]       slip_cnt_q, slip_cnt_d;

    // Next-state logic: a completed token run beats an expiring window.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        win_d      = win_q;
        settle_d   = settle_q;
        sil_d      = sil_q;
        bitslip_d  = 1'b0;
        locked_d   = locked_q;
        slip_cnt_d = slip_cnt_q;
        case (state_q)
            ST_SEARCH: begin
                run_d = ctrl_tok_i ? (run_q + RUN_ONE) : {RUN_W{1'b0}};
                win_d = win_q + WIN_ONE;
                if (ctrl_tok_i && (run_q == RUN_LAST)) begin
                    state_d  = ST_LOCKED;
                    locked_d = 1'b1;
                    run_d    = {RUN_W{1'b0}};
                    win_d    = {WIN_W{1'b0}};
                    sil_d    = {SIL_W{1'b0}};
                end else if (win_q == WIN_LAST) begin
                    state_d    = ST_SLIP_WAIT;
                    bitslip_d  = 1'b1;
                    slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : (slip_cnt_q + 4'd1);
                    settle_d   = {SET_W{1'b0}};
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_SLIP_WAIT: begin
                settle_d = settle_q + SET_ONE;
                if (settle_q == SET_LAST) begin
                    state_d  = ST_SEARCH;
                    run_d    = {RUN_W{1'b0}};
                    win_d    = {WIN_W{1'b0}};
                    settle_d = {SET_W{1'b0}};
                end else begin
                    state_d = ST_SLIP_WAIT;
                end
            end
            ST_LOCKED: begin
                if (ctrl_tok_i) begin
                    sil_d = {SIL_W{1'b0}};
                end else if (sil_q == SIL_LAST) begin
                    state_d    = ST_SEARCH;
                    locked_d   = 1'b0;
                    slip_cnt_d = 4'd0;
                    run_d      = {RUN_W{1'b0}};
                    win_d      = {WIN_W{1'b0}};
                    sil_d      = {SIL_W{1'b0}};
                end else begin
                    sil_d = sil_q + SIL_ONE;
                end
            end
            default: begin
                state_d  = ST_SEARCH;
                locked_d = 1'b0;
                run_d    = {RUN_W{1'b0}};
                win_d    = {WIN_W{1'b0}};
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_SEARCH;
            run_q      <= {RUN_W{1'b0}};
            win_q      <= {WIN_W{1'b0}};
            settle_q   <= {SET_W{1'b0}};
            sil_q      <= {SIL_W{1'b0}};
            bitslip_q  <= 1'b0;
            locked_q   <= 1'b0;
            slip_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            win_q      <= win_d;
            settle_q   <= settle_d;
            sil_q      <= sil_d;
            bitslip_q  <= bitslip_d;
            locked_q   <= locked_d;
            slip_cnt_q <= slip_cnt_d;
        end
    end

    assign bitslip_o    = bitslip_q;
    assign locked_o     = locked_q;
    assign lock_next_o  = locked_d;
    assign slip_count_o = slip_cnt_q;

endmodule

// File: rtl/tmds_rx_decoder.sv
// TMDS receive channel: word alignment plus registered 10b->8b decode of
// pixel data and control tokens.
module tmds_rx_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN      = 16,
    parameter int SEARCH_WINDOW = 2048,
    parameter int SLIP_SETTLE   = 4,
    parameter int LOSS_TIMEOUT  = 4096
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [9:0] din,
    output logic       bitslip,
    output logic       locked,
    output logic [3:0] slip_count,
    output logic       valid,
    output logic       de,
    output logic [7:0] dout,
    output logic [1:0] ctrl
);

    logic       ctrl_tok_s;
    logic [1:0] tok_ctrl_s;
    logic [7:0] data_s;
    logic       lock_next_s;

    logic       valid_q, valid_d;
    logic       de_q, de_d;
    logic [7:0] dout_q, dout_d;
    logic [1:0] ctrl_q, ctrl_d;

    assign ctrl_tok_s = is_ctrl_token(din);
    assign tok_ctrl_s = token_to_ctrl(din);
    assign data_s     = tmds_decode(din);

    tmds_word_align #(
        .CTRL_RUN      (CTRL_RUN),
        .SEARCH_WINDOW (SEARCH_WINDOW),
        .SLIP_SETTLE   (SLIP_SETTLE),
        .LOSS_TIMEOUT  (LOSS_TIMEOUT)
    ) u_align (
        .clk_i        (pixel_clk),
        .rst_ni       (rst),
        .ctrl_tok_i   (ctrl_tok_s),
        .bitslip_o    (bitslip),
        .locked_o     (locked),
        .lock_next_o  (lock_next_s),
        .slip_count_o (slip_count)
    );

    // Output qualifiers follow the next lock state so valid tracks locked.
    always_comb begin
        valid_d = lock_next_s;
        de_d    = 1'b0;
        dout_d  = 8'h00;
        ctrl_d  = ctrl_q;
        if (lock_next_s) begin
            if (ctrl_tok_s) begin
                ctrl_d = tok_ctrl_s;
            end else begin
                de_d   = 1'b1;
                dout_d = data_s;
            end
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // Output registers.
    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            de_q    <= 1'b0;
            dout_q  <= 8'h00;
            ctrl_q  <= 2'b00;
        end else begin
            valid_q <= valid_d;
            de_q    <= de_d;
            dout_q  <= dout_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid = valid_q;
    assign de    = de_q;
    assign dout  = dout_q;
    assign ctrl  = ctrl_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Directed bench for tmds_rx_decoder: reset, lock, decode, loss of lock,
// bitslip alignment and reset during the slip settle period.
module tb_tmds_rx_decoder;

    logic       pixel_clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       bitslip;
    logic       locked;
    logic [3:0] slip_count;
    logic       valid;
    logic       de;
    logic [7:0] dout;
    logic [1:0] ctrl;

    int total = 0;
    int bad   = 0;
    int disp  = 0;

    tmds_rx_decoder dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .din        (din),
        .bitslip    (bitslip),
        .locked     (locked),
        .slip_count (slip_count),
        .valid      (valid),
        .de         (de),
        .dout       (dout),
        .ctrl       (ctrl)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [9:0] w);
        din = w;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) tick(10'h354);
        rst = 1'b1;
    endtask

    function automatic logic [9:0] rot(input logic [9:0] w, input int off);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = w[(i + off) % 10];
        return r;
    endfunction

    function automatic logic is_tok(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    // Reference DVI transmit encoder with running disparity.
    task automatic encode(input logic [7:0] d, output logic [9:0] w);
        logic [8:0] qm;
        int n1d, n1q, n0q;
        n1d   = $countones(d);
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            w[9]   = ~qm[8];
            w[8]   = qm[8];
            w[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
            disp   = qm[8] ? (disp + n1q - n0q) : (disp + n0q - n1q);
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            w[9]   = 1'b1;
            w[8]   = qm[8];
            w[7:0] = ~qm[7:0];
            disp   = disp + 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            w[9]   = 1'b0;
            w[8]   = qm[8];
            w[7:0] = qm[7:0];
            disp   = disp - 2 * int'(!qm[8]) + n1q - n0q;
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [9:0] w;
        int off;
        int slips;

        rst = 1'b0;
        din = 10'h354;
        do_reset();
        chk("rst_bitslip", 32'(bitslip), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_slip_count", 32'(slip_count), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_ctrl", 32'(ctrl), 32'd0);

        for (int i = 1; i <= 16; i++) begin
            tick(10'h354);
            if (i == 15) chk("lock_early", 32'(locked), 32'd0);
        end
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_valid", 32'(valid), 32'd1);
        chk("lock_de", 32'(de), 32'd0);
        chk("lock_ctrl", 32'(ctrl), 32'd0);
        chk("lock_dout", 32'(dout), 32'd0);

        tick(10'h100);
        chk("dec_100_dout", 32'(dout), 32'h00);
        chk("dec_100_de", 32'(de), 32'd1);
        tick(10'h2FF);
        chk("dec_2ff_dout", 32'(dout), 32'hFE);
        tick(10'h154);
        chk("tok154_de", 32'(de), 32'd0);
        chk("tok154_ctrl", 32'(ctrl), 32'd2);
        chk("tok154_dout", 32'(dout), 32'd0);
        tick(10'h2AB);
        chk("tok2ab_ctrl", 32'(ctrl), 32'd3);
        tick(10'h0AB);
        chk("tok0ab_ctrl", 32'(ctrl), 32'd1);
        tick(10'h100);
        chk("ctrl_hold", 32'(ctrl), 32'd1);
        chk("ctrl_hold_de", 32'(de), 32'd1);

        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            encode(b, w);
            tick(w);
            chk("rand_dout", 32'(dout), 32'(b));
            chk("rand_de", 32'(de), 32'd1);
        end

        tick(10'h354);
        for (int i = 1; i <= 4096; i++) begin
            tick(10'h100);
            if (i == 4095) chk("loss_early", 32'(locked), 32'd1);
        end
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_valid", 32'(valid), 32'd0);
        chk("loss_de", 32'(de), 32'd0);
        chk("loss_dout", 32'(dout), 32'd0);
        chk("loss_ctrl", 32'(ctrl), 32'd0);
        chk("loss_slip_count", 32'(slip_count), 32'd0);

        do_reset();
        for (int i = 0; i < 2032; i++) tick(10'h100);
        for (int i = 0; i < 16; i++) tick(10'h354);
        chk("tie_locked", 32'(locked), 32'd1);
        chk("tie_bitslip", 32'(bitslip), 32'd0);
        chk("tie_slip_count", 32'(slip_count), 32'd0);
        tick(10'h354);
        chk("tie_bitslip_after", 32'(bitslip), 32'd0);

        do_reset();
        off   = 3;
        slips = 0;
        while (!is_tok(rot(10'h0AB, off)) && slips < 10) begin
            for (int c = 1; c <= 2048; c++) begin
                tick(rot(10'h0AB, off));
                if (c == 2047) chk("align_pre_slip", 32'(bitslip), 32'd0);
                if (c == 2048) chk("align_slip", 32'(bitslip), 32'd1);
            end
            slips++;
            off = (off + 1) % 10;
            for (int c = 1; c <= 4; c++) begin
                tick(rot(10'h0AB, off));
                if (c == 1) chk("align_slip_single", 32'(bitslip), 32'd0);
            end
            chk("align_slip_count", 32'(slip_count), 32'(slips % 10));
        end
        for (int c = 1; c <= 16; c++) begin
            tick(rot(10'h0AB, off));
            if (c == 15) chk("align_lock_early", 32'(locked), 32'd0);
        end
        chk("align_locked", 32'(locked), 32'd1);
        chk("align_slips", 32'(slip_count), 32'(slips));
        chk("align_ctrl", 32'(ctrl), 32'd1);

        do_reset();
        for (int c = 1; c <= 2048; c++) tick(10'h100);
        chk("sw_slip", 32'(bitslip), 32'd1);
        chk("sw_slip_count", 32'(slip_count), 32'd1);
        rst = 1'b0;
        tick(10'h100);
        rst = 1'b1;
        chk("sw_rst_slip_count", 32'(slip_count), 32'd0);
        chk("sw_rst_bitslip", 32'(bitslip), 32'd0);
        for (int c = 1; c <= 2048; c++) begin
            tick(10'h100);
            if (c == 4) chk("sw_no_stale_exit", 32'(bitslip), 32'd0);
            if (c == 2047) chk("sw_window_early", 32'(bitslip), 32'd0);
            if (c == 2048) chk("sw_window_slip", 32'(bitslip), 32'd1);
        end
        chk("sw_locked", 32'(locked), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
